// File: rtl/decode_pipe_ctrl_pkg.sv
// Shared constants and types for the registered decode stage.
// Opcodes, func7 values, memory type codes, FSM states, control bundle.
package decode_pipe_ctrl_pkg;

  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BTYPE = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [1:0] STORE_SB  = 2'b00;
  localparam logic [1:0] STORE_SH  = 2'b01;
  localparam logic [1:0] STORE_SW  = 2'b10;
  localparam logic [1:0] STORE_DEF = 2'b11;

  localparam logic [2:0] LOAD_LB  = 3'b000;
  localparam logic [2:0] LOAD_LH  = 3'b001;
  localparam logic [2:0] LOAD_LW  = 3'b010;
  localparam logic [2:0] LOAD_LBU = 3'b011;
  localparam logic [2:0] LOAD_LHU = 3'b100;
  localparam logic [2:0] LOAD_DEF = 3'b111;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_TRAP = 1'b1
  } state_e;

  typedef struct packed {
    logic       alu_src;
    logic       muldiv;
    logic       br;
    logic       jmp;
    logic       mem_write;
    logic [1:0] store_type;
    logic [2:0] load_type;
    logic       wb_load;
    logic       wb_reg_file;
    logic       invalid;
  } ctrl_t;

  // Bundle with every side effect disabled and default memory types.
  function automatic ctrl_t ctrl_safe();
    ctrl_t c;
    c            = '0;
    c.store_type = STORE_DEF;
    c.load_type  = LOAD_DEF;
    return c;
  endfunction

endpackage

// File: rtl/decode_pipe_ctrl_if.sv
// Fetch-side, EX-side and trap handshake signals of the decode stage.
// slave = the stage itself, master = its environment.
interface decode_pipe_ctrl_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      inst_in;
  logic [XLEN-1:0]  pc_in;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  pc_out;
  logic             ex_alu_src;
  logic             ex_muldiv;
  logic             br_inst;
  logic             jmp_inst;
  logic             mem_write;
  logic [1:0]       mem_store_type;
  logic [2:0]       mem_load_type;
  logic             wb_load;
  logic             wb_reg_file;
  logic             invalid_inst;
  logic             trap_req;
  logic [XLEN-1:0]  trap_pc;
  logic             trap_ack;
  logic [CNT_W-1:0] illegal_cnt;

  modport slave (
    input  in_valid, inst_in, pc_in, flush, out_ready, trap_ack,
    output in_ready, out_valid, pc_out, ex_alu_src, ex_muldiv,
    output br_inst, jmp_inst, mem_write, mem_store_type,
    output mem_load_type, wb_load, wb_reg_file, invalid_inst,
    output trap_req, trap_pc, illegal_cnt
  );

  modport master (
    output in_valid, inst_in, pc_in, flush, out_ready, trap_ack,
    input  in_ready, out_valid, pc_out, ex_alu_src, ex_muldiv,
    input  br_inst, jmp_inst, mem_write, mem_store_type,
    input  mem_load_type, wb_load, wb_reg_file, invalid_inst,
    input  trap_req, trap_pc, illegal_cnt
  );
endinterface

// File: rtl/decode_pipe_ctrl_fields.sv
// Combinational RV32I(+M) field decoder: instruction word to controls.
// Illegal encodings come out as the safe bundle with invalid set.
module decode_pipe_ctrl_fields
  import decode_pipe_ctrl_pkg::*;
#(
  parameter bit EN_MULDIV = 1'b0
) (
  input  logic [31:0] inst_i,
  output ctrl_t       ctrl_o
);

  logic [6:0] op;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       legal;
  ctrl_t      c;
  logic       unused_bits;

  assign op = inst_i[6:0];
  assign f3 = inst_i[14:12];
  assign f7 = inst_i[31:25];
  assign unused_bits = ^{inst_i[24:15], inst_i[11:7]};

  // Per-opcode legality and control generation.
  always_comb begin
    c     = ctrl_safe();
    legal = 1'b0;
    case (op)
      OP_RTYPE: begin
        c.wb_reg_file = 1'b1;
        case (f7)
          F7_BASE:   legal = 1'b1;
          F7_ALT:    legal = (f3 == 3'b000) || (f3 == 3'b101);
          F7_MULDIV: begin
            legal    = EN_MULDIV;
            c.muldiv = EN_MULDIV;
          end
          default:   legal = 1'b0;
        endcase
      end
      OP_ITYPE: begin
        c.alu_src     = 1'b1;
        c.wb_reg_file = 1'b1;
        if (f3 == 3'b001)
          legal = (f7 == F7_BASE);
        else if (f3 == 3'b101)
          legal = (f7 == F7_BASE) || (f7 == F7_ALT);
        else
          legal = 1'b1;
      end
      OP_LOAD: begin
        c.alu_src     = 1'b1;
        c.wb_reg_file = 1'b1;
        c.wb_load     = 1'b1;
        legal         = 1'b1;
        case (f3)
          3'b000:  c.load_type = LOAD_LB;
          3'b001:  c.load_type = LOAD_LH;
          3'b010:  c.load_type = LOAD_LW;
          3'b100:  c.load_type = LOAD_LBU;
          3'b101:  c.load_type = LOAD_LHU;
          default: legal = 1'b0;
        endcase
      end
      OP_STORE: begin
        c.alu_src   = 1'b1;
        c.mem_write = 1'b1;
        legal       = 1'b1;
        case (f3)
          3'b000:  c.store_type = STORE_SB;
          3'b001:  c.store_type = STORE_SH;
          3'b010:  c.store_type = STORE_SW;
          default: legal = 1'b0;
        endcase
      end
      OP_BTYPE: begin
        c.br  = 1'b1;
        legal = (f3 != 3'b010) && (f3 != 3'b011);
      end
      OP_JAL: begin
        c.jmp         = 1'b1;
        c.wb_reg_file = 1'b1;
        legal         = 1'b1;
      end
      OP_JALR: begin
        c.jmp         = 1'b1;
        c.alu_src     = 1'b1;
        c.wb_reg_file = 1'b1;
        legal         = (f3 == 3'b000);
      end
      OP_LUI, OP_AUIPC: begin
        c.alu_src     = 1'b1;
        c.wb_reg_file = 1'b1;
        legal         = 1'b1;
      end
      default: legal = 1'b0;
    endcase
    ctrl_o = c;
    if (!legal) begin
      ctrl_o         = ctrl_safe();
      ctrl_o.invalid = 1'b1;
    end
  end

endmodule

// File: rtl/decode_pipe_ctrl.sv
// Registered decode stage: valid/ready pipeline register with flush,
// trap FSM on illegal instructions and a saturating illegal counter.
module decode_pipe_ctrl
  import decode_pipe_ctrl_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter bit EN_MULDIV = 1'b0,
  parameter int CNT_W     = 8
) (
  input logic          clk,
  input logic          rst,
  decode_pipe_ctrl_if.slave bus
);

  ctrl_t            dec;
  ctrl_t            ctrl_q;
  logic [XLEN-1:0]  pc_q;
  logic             out_valid_q;
  logic [XLEN-1:0]  trap_pc_q;
  logic [CNT_W-1:0] cnt_q;
  state_e           state_q;
  state_e           state_d;
  logic             trap_req;
  logic             in_ready;
  logic             accept;
  logic             take_trap;

  decode_pipe_ctrl_fields #(
    .EN_MULDIV (EN_MULDIV)
  ) u_fields (
    .inst_i (bus.inst_in),
    .ctrl_o (dec)
  );

  assign in_ready  = (state_q == ST_RUN) && !bus.flush &&
                     (!out_valid_q || bus.out_ready);
  assign accept    = bus.in_valid && in_ready;
  assign take_trap = accept && dec.invalid;

  // Pipeline register: load on accept, hold under stall, kill on flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      ctrl_q      <= ctrl_safe();
      pc_q        <= '0;
    end else begin
      if (bus.flush)
        out_valid_q <= 1'b0;
      else if (accept)
        out_valid_q <= 1'b1;
      else if (bus.out_ready)
        out_valid_q <= 1'b0;
      if (accept) begin
        ctrl_q <= dec;
        pc_q   <= bus.pc_in;
      end
    end
  end

  // Trap pc capture and saturating illegal-instruction counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      trap_pc_q <= '0;
      cnt_q     <= '0;
    end else if (take_trap) begin
      trap_pc_q <= bus.pc_in;
      if (!(&cnt_q))
        cnt_q <= cnt_q + 1'b1;
    end
  end

  // Trap FSM state register.
  always_ff @(posedge clk) begin
    if (rst)
      state_q <= ST_RUN;
    else
      state_q <= state_d;
  end

  // Trap FSM next state and trap request.
  always_comb begin
    state_d  = state_q;
    trap_req = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (take_trap)
          state_d = ST_TRAP;
      end
      ST_TRAP: begin
        trap_req = 1'b1;
        if (bus.trap_ack)
          state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  assign bus.in_ready       = in_ready;
  assign bus.out_valid      = out_valid_q;
  assign bus.pc_out         = pc_q;
  assign bus.ex_alu_src     = ctrl_q.alu_src;
  assign bus.ex_muldiv      = ctrl_q.muldiv;
  assign bus.br_inst        = ctrl_q.br;
  assign bus.jmp_inst       = ctrl_q.jmp;
  assign bus.mem_write      = ctrl_q.mem_write;
  assign bus.mem_store_type = ctrl_q.store_type;
  assign bus.mem_load_type  = ctrl_q.load_type;
  assign bus.wb_load        = ctrl_q.wb_load;
  assign bus.wb_reg_file    = ctrl_q.wb_reg_file;
  assign bus.invalid_inst   = ctrl_q.invalid;
  assign bus.trap_req       = trap_req;
  assign bus.trap_pc        = trap_pc_q;
  assign bus.illegal_cnt    = cnt_q;

endmodule

// File: tb/tb_decode_pipe_ctrl.sv
// Directed bench for decode_pipe_ctrl: default build plus a
// MULDIV-enabled build with a 2-bit counter.
module tb_decode_pipe_ctrl;

  localparam logic [31:0] I_LW   = 32'h00012083;
  localparam logic [31:0] I_SW   = 32'h00112223;
  localparam logic [31:0] I_ADD  = 32'h002081b3;
  localparam logic [31:0] I_SUB  = 32'h402081b3;
  localparam logic [31:0] I_SLLX = 32'h402091b3;
  localparam logic [31:0] I_MUL  = 32'h022081b3;
  localparam logic [31:0] I_JAL  = 32'h0000006f;
  localparam logic [31:0] I_BAD  = 32'hffffffff;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  logic [1:0] exp_cnt;

  decode_pipe_ctrl_if #(.XLEN(32), .CNT_W(8)) a ();
  decode_pipe_ctrl_if #(.XLEN(32), .CNT_W(2)) b ();

  decode_pipe_ctrl #(
    .XLEN(32), .EN_MULDIV(1'b0), .CNT_W(8)
  ) u0 (
    .clk (clk),
    .rst (rst),
    .bus (a)
  );

  decode_pipe_ctrl #(
    .XLEN(32), .EN_MULDIV(1'b1), .CNT_W(2)
  ) u1 (
    .clk (clk),
    .rst (rst),
    .bus (b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string       tag,
    input logic [31:0] o,
    input logic [31:0] e
  );
    total++;
    if (o !== e) begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  initial begin
    rst = 1'b1;
    a.in_valid = 0; a.inst_in = 0; a.pc_in = 0;
    a.flush = 0; a.out_ready = 0; a.trap_ack = 0;
    b.in_valid = 0; b.inst_in = 0; b.pc_in = 0;
    b.flush = 0; b.out_ready = 0; b.trap_ack = 0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_out_valid", a.out_valid, 1'b0);
    chk("rst_trap_req", a.trap_req, 1'b0);
    chk("rst_trap_pc", a.trap_pc, 32'h0);
    chk("rst_cnt", a.illegal_cnt, 8'h00);
    chk("rst_pc_out", a.pc_out, 32'h0);
    chk("rst_store_type", a.mem_store_type, 2'b11);
    chk("rst_load_type", a.mem_load_type, 3'b111);
    chk("rst_wb_reg", a.wb_reg_file, 1'b0);
    chk("rst_mem_write", a.mem_write, 1'b0);
    chk("rst_invalid", a.invalid_inst, 1'b0);
    chk("rst_in_ready", a.in_ready, 1'b1);
    chk("rst_cnt_b", b.illegal_cnt, 2'b00);

    a.out_ready = 1; a.in_valid = 1;
    a.inst_in = I_LW; a.pc_in = 32'h100;
    #1;
    chk("lw_in_ready", a.in_ready, 1'b1);
    tick();
    a.in_valid = 0;
    chk("lw_valid", a.out_valid, 1'b1);
    chk("lw_load_type", a.mem_load_type, 3'b010);
    chk("lw_wb_load", a.wb_load, 1'b1);
    chk("lw_wb_reg", a.wb_reg_file, 1'b1);
    chk("lw_alu_src", a.ex_alu_src, 1'b1);
    chk("lw_pc_out", a.pc_out, 32'h100);
    chk("lw_invalid", a.invalid_inst, 1'b0);
    chk("lw_mem_write", a.mem_write, 1'b0);
    tick();
    chk("lw_drain", a.out_valid, 1'b0);

    a.out_ready = 0; a.in_valid = 1;
    a.inst_in = I_SW; a.pc_in = 32'h104;
    tick();
    a.inst_in = I_ADD; a.pc_in = 32'h108;
    #1;
    chk("sw_valid", a.out_valid, 1'b1);
    chk("sw_store_type", a.mem_store_type, 2'b10);
    chk("sw_mem_write", a.mem_write, 1'b1);
    chk("sw_wb_reg", a.wb_reg_file, 1'b0);
    chk("sw_stall_ready", a.in_ready, 1'b0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("stall_valid", a.out_valid, 1'b1);
      chk("stall_pc", a.pc_out, 32'h104);
      chk("stall_store", a.mem_store_type, 2'b10);
      chk("stall_ready", a.in_ready, 1'b0);
    end
    a.out_ready = 1;
    #1;
    chk("release_ready", a.in_ready, 1'b1);
    tick();
    a.in_valid = 0;
    chk("add_pc", a.pc_out, 32'h108);
    chk("add_wb_reg", a.wb_reg_file, 1'b1);
    chk("add_alu_src", a.ex_alu_src, 1'b0);
    chk("add_store", a.mem_store_type, 2'b11);
    chk("add_load", a.mem_load_type, 3'b111);
    chk("add_mem_write", a.mem_write, 1'b0);

    a.in_valid = 1; a.inst_in = I_MUL; a.pc_in = 32'h200;
    tick();
    a.in_valid = 0;
    chk("mul_invalid", a.invalid_inst, 1'b1);
    chk("mul_trap_req", a.trap_req, 1'b1);
    chk("mul_trap_pc", a.trap_pc, 32'h200);
    chk("mul_cnt", a.illegal_cnt, 8'h01);
    chk("mul_wb_reg", a.wb_reg_file, 1'b0);
    chk("mul_muldiv", a.ex_muldiv, 1'b0);
    chk("mul_valid", a.out_valid, 1'b1);

    a.in_valid = 1; a.inst_in = I_ADD; a.pc_in = 32'h204;
    #1;
    chk("trap_ready", a.in_ready, 1'b0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("trap_hold_ready", a.in_ready, 1'b0);
      chk("trap_hold_req", a.trap_req, 1'b1);
    end
    chk("trap_no_valid", a.out_valid, 1'b0);
    chk("trap_no_pc", a.pc_out, 32'h200);
    a.trap_ack = 1;
    #1;
    chk("ack_cycle_ready", a.in_ready, 1'b0);
    tick();
    a.trap_ack = 0;
    #1;
    chk("post_ack_req", a.trap_req, 1'b0);
    chk("post_ack_valid", a.out_valid, 1'b0);
    chk("post_ack_ready", a.in_ready, 1'b1);
    tick();
    a.in_valid = 0;
    chk("resume_valid", a.out_valid, 1'b1);
    chk("resume_pc", a.pc_out, 32'h204);

    a.out_ready = 0; a.in_valid = 1;
    a.inst_in = I_LW; a.pc_in = 32'h300; a.flush = 1;
    #1;
    chk("flush_ready", a.in_ready, 1'b0);
    tick();
    a.flush = 0; a.in_valid = 0;
    chk("flush_valid", a.out_valid, 1'b0);
    chk("flush_pc", a.pc_out, 32'h204);

    a.in_valid = 1; a.inst_in = I_BAD; a.pc_in = 32'h400;
    tick();
    a.in_valid = 0;
    chk("bad_trap_req", a.trap_req, 1'b1);
    chk("bad_invalid", a.invalid_inst, 1'b1);
    chk("bad_cnt", a.illegal_cnt, 8'h02);
    chk("bad_mem_write", a.mem_write, 1'b0);
    a.flush = 1;
    tick();
    a.flush = 0;
    chk("bad_flush_valid", a.out_valid, 1'b0);
    chk("bad_flush_req", a.trap_req, 1'b1);
    chk("bad_trap_pc", a.trap_pc, 32'h400);
    a.trap_ack = 1;
    tick();
    a.trap_ack = 0;
    chk("bad_acked", a.trap_req, 1'b0);

    a.out_ready = 1; a.in_valid = 1;
    a.inst_in = I_SLLX; a.pc_in = 32'h500;
    tick();
    a.in_valid = 0;
    chk("sllx_invalid", a.invalid_inst, 1'b1);
    chk("sllx_cnt", a.illegal_cnt, 8'h03);
    chk("sllx_trap_pc", a.trap_pc, 32'h500);
    a.trap_ack = 1;
    tick();
    a.trap_ack = 0;

    a.in_valid = 1; a.inst_in = I_SUB; a.pc_in = 32'h600;
    tick();
    chk("sub_invalid", a.invalid_inst, 1'b0);
    chk("sub_trap_req", a.trap_req, 1'b0);
    chk("sub_wb_reg", a.wb_reg_file, 1'b1);
    chk("sub_cnt", a.illegal_cnt, 8'h03);

    a.inst_in = I_JAL; a.pc_in = 32'h604;
    tick();
    a.in_valid = 0;
    chk("jal_jmp", a.jmp_inst, 1'b1);
    chk("jal_alu_src", a.ex_alu_src, 1'b0);
    chk("jal_wb_reg", a.wb_reg_file, 1'b1);
    chk("jal_pc", a.pc_out, 32'h604);

    a.in_valid = 1; a.inst_in = I_BAD; a.pc_in = 32'h700;
    tick();
    a.in_valid = 0;
    chk("pre_rst_req", a.trap_req, 1'b1);
    chk("pre_rst_cnt", a.illegal_cnt, 8'h04);
    rst = 1;
    tick();
    rst = 0;
    chk("mid_rst_req", a.trap_req, 1'b0);
    chk("mid_rst_cnt", a.illegal_cnt, 8'h00);
    chk("mid_rst_valid", a.out_valid, 1'b0);
    chk("mid_rst_trap_pc", a.trap_pc, 32'h0);
    chk("mid_rst_pc", a.pc_out, 32'h0);

    b.out_ready = 1; b.in_valid = 1;
    b.inst_in = I_MUL; b.pc_in = 32'h800;
    tick();
    b.in_valid = 0;
    chk("m_muldiv", b.ex_muldiv, 1'b1);
    chk("m_invalid", b.invalid_inst, 1'b0);
    chk("m_trap_req", b.trap_req, 1'b0);
    chk("m_wb_reg", b.wb_reg_file, 1'b1);
    chk("m_alu_src", b.ex_alu_src, 1'b0);

    for (int i = 0; i < 4; i++) begin
      b.in_valid = 1; b.inst_in = I_BAD;
      b.pc_in = 32'h900 + 32'(4 * i);
      tick();
      b.in_valid = 0;
      exp_cnt = (i < 3) ? 2'(i + 1) : 2'b11;
      chk("sat_cnt", b.illegal_cnt, exp_cnt);
      chk("sat_trap_req", b.trap_req, 1'b1);
      b.trap_ack = 1;
      tick();
      b.trap_ack = 0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
